// File: rtl/sdram_axi_rd_splitter.sv
// AXI4 read burst splitter: breaks one upstream INCR burst into sub-bursts of at most
// MAX_BEATS beats that never cross a 2^BOUNDARY_W-byte row, with one RLAST for the whole burst.
module sdram_axi_rd_splitter #(
  parameter int unsigned MAX_BEATS  = 8,
  parameter int unsigned BOUNDARY_W = 11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_arvalid_i,
  input  logic [31:0] inport_araddr_i,
  input  logic [3:0]  inport_arid_i,
  input  logic [7:0]  inport_arlen_i,
  input  logic [1:0]  inport_arburst_i,
  output logic        inport_arready_o,
  output logic        inport_rvalid_o,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [3:0]  inport_rid_o,
  output logic        inport_rlast_o,
  input  logic        inport_rready_i,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o
);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [8:0] MaxBeats   = 9'(MAX_BEATS);

  typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;

  state_e      r_state;
  logic [31:0] r_addr;
  logic [8:0]  r_rem;
  logic [8:0]  r_n;
  logic [3:0]  r_id;
  logic [1:0]  r_burst;
  logic        r_arready;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;

  logic [31:0] w_calc_addr;
  logic [8:0]  w_calc_rem;
  logic [1:0]  w_calc_burst;
  logic [8:0]  w_rem_in;
  logic [31:0] w_bnd;
  logic [8:0]  w_n;
  logic [8:0]  w_nm1;
  logic        w_data;
  logic        w_r_last_hs;
  logic        w_unused;

  assign w_rem_in = {1'b0, inport_arlen_i} + 9'd1;

  // Sub-burst size is computed from the incoming AR in IDLE, else from the running state.
  always_comb begin
    w_calc_addr  = r_addr;
    w_calc_rem   = r_rem;
    w_calc_burst = r_burst;
    if (r_state == StIdle) begin
      w_calc_addr  = inport_araddr_i;
      w_calc_rem   = w_rem_in;
      w_calc_burst = inport_arburst_i;
    end
    w_bnd = ((32'd1 << BOUNDARY_W) -
             {{(32-BOUNDARY_W){1'b0}}, w_calc_addr[BOUNDARY_W-1:0]}) >> 2;
    w_n = w_calc_rem;
    if (w_calc_burst == BurstIncr) begin
      if (w_n > MaxBeats) w_n = MaxBeats;
      if (w_bnd < {23'd0, w_n}) w_n = w_bnd[8:0];
    end
    w_nm1 = w_n - 9'd1;
  end

  assign w_data      = (r_state == StData);
  assign w_r_last_hs = w_data && outport_rvalid_i && inport_rready_i && outport_rlast_i;
  assign w_unused    = ^{outport_rid_i, w_nm1[8]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_rem     <= '0;
      r_n       <= '0;
      r_id      <= '0;
      r_burst   <= '0;
      r_arready <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_arready <= 1'b1;
          if (inport_arvalid_i && r_arready) begin
            r_arready <= 1'b0;
            r_addr    <= inport_araddr_i;
            r_id      <= inport_arid_i;
            r_burst   <= inport_arburst_i;
            r_rem     <= w_rem_in;
            r_n       <= w_n;
            r_arvalid <= 1'b1;
            r_araddr  <= inport_araddr_i;
            r_arlen   <= w_nm1[7:0];
            r_state   <= StIssue;
          end
        end
        StIssue: begin
          if (outport_arready_i) begin
            r_arvalid <= 1'b0;
            r_rem     <= r_rem - r_n;
            if (r_burst != BurstFixed) r_addr <= r_addr + {21'd0, r_n, 2'b00};
            r_state   <= StData;
          end
        end
        StData: begin
          if (w_r_last_hs) begin
            if (r_rem == 9'd0) begin
              r_arready <= 1'b1;
              r_state   <= StIdle;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= r_addr;
              r_arlen   <= w_nm1[7:0];
              r_n       <= w_n;
              r_state   <= StIssue;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign inport_arready_o  = r_arready;
  assign outport_arvalid_o = r_arvalid;
  assign outport_araddr_o  = r_araddr;
  assign outport_arlen_o   = r_arlen;
  assign outport_arid_o    = r_id;
  assign outport_arburst_o = r_burst;
  assign inport_rid_o      = r_id;

  assign inport_rvalid_o  = w_data && outport_rvalid_i;
  assign outport_rready_o = w_data && inport_rready_i;
  assign inport_rdata_o   = w_data ? outport_rdata_i : 32'd0;
  assign inport_rresp_o   = w_data ? outport_rresp_i : 2'd0;
  assign inport_rlast_o   = w_data && outport_rlast_i && (r_rem == 9'd0);

endmodule
